// File: rtl/lane_ram.sv
// lane_ram: byte-interleaved RAM with an unaligned fetch read port and an unaligned data read/write port.
// Latency: RD_LAT (1 or 2) cycles on both ports, fully pipelined, one request per port per cycle.
// Backpressure: none, requests are never stalled; define LANE_RAM_BYPASS_EN for write-to-fetch forwarding.
module lane_ram #(
    parameter int LANES      = 4,
    parameter int DATA_BYTES = 2,
    parameter int ADR_W      = 16,
    parameter int RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADR_W-1:0]        iadr,
    input  logic                    ien,
    output logic [8*LANES-1:0]      idata,
    output logic                    ivalid,
    input  logic [ADR_W-1:0]        dadr,
    input  logic                    dre,
    input  logic [DATA_BYTES-1:0]   dwe,
    input  logic [8*DATA_BYTES-1:0] dwdata,
    output logic [8*DATA_BYTES-1:0] drdata,
    output logic                    dvalid
);
    localparam int OFF_W = $clog2(LANES);
    localparam int ROW_W = ADR_W - OFF_W;
    localparam int DEPTH = 2**ROW_W;

    // Split byte addresses into row base and lane offset.
    logic [ROW_W-1:0] ibase, dbase;
    logic [OFF_W-1:0] ioff, doff;
    assign ibase = iadr[ADR_W-1:OFF_W];
    assign ioff  = iadr[OFF_W-1:0];
    assign dbase = dadr[ADR_W-1:OFF_W];
    assign doff  = dadr[OFF_W-1:0];

    // Zero-extended write controls so every lane can index them directly.
    logic [LANES-1:0]   dwe_x;
    logic [8*LANES-1:0] dwdata_x;
    assign dwe_x    = LANES'(dwe);
    assign dwdata_x = (8*LANES)'(dwdata);

    // Raw per-lane read registers, in lane order.
    logic [8*LANES-1:0] ilane, dlane;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [OFF_W-1:0] K = OFF_W'(k);

        logic [7:0]       mem [DEPTH];
        logic [ROW_W-1:0] irow, drow;
        logic [OFF_W-1:0] wsel;
        logic             wen;
        logic [7:0]       wbyte;
        logic [7:0]       iq, dq;

        // Lanes below the offset belong to the next row; the add wraps modulo depth.
        assign irow  = ibase + ROW_W'(K < ioff);
        assign drow  = dbase + ROW_W'(K < doff);
        // Data byte landing in this lane is (lane - offset) mod LANES.
        assign wsel  = K - doff;
        assign wen   = dwe_x[wsel] & ~reset;
        assign wbyte = dwdata_x[8*wsel +: 8];

        // Byte write from the data port; writes seen while reset is high are dropped.
        always_ff @(posedge clk) begin
            if (wen) begin
                mem[drow] <= wbyte;
            end
        end

        // Fetch read register: old contents on a same-cycle write unless forwarding is built in.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                iq <= '0;
            end else if (ien) begin
`ifdef LANE_RAM_BYPASS_EN
                iq <= (wen && (drow == irow)) ? wbyte : mem[irow];
`else
                iq <= mem[irow];
`endif
            end
        end

        // Data read register: always read-first against the data-port write.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dq <= '0;
            end else if (dre) begin
                dq <= mem[drow];
            end
        end

        assign ilane[8*k +: 8] = iq;
        assign dlane[8*k +: 8] = dq;
    end

    // First-stage valids and rotate offsets; offsets hold so outputs hold between requests.
    logic             ivld_q, dvld_q;
    logic [OFF_W-1:0] ioff_q, doff_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ivld_q <= 1'b0;
            dvld_q <= 1'b0;
            ioff_q <= '0;
            doff_q <= '0;
        end else begin
            ivld_q <= ien;
            dvld_q <= dre;
            if (ien) begin
                ioff_q <= ioff;
            end
            if (dre) begin
                doff_q <= doff;
            end
        end
    end

    // Rotate fetch lanes into byte order starting at the registered offset.
    logic [8*LANES-1:0] irot;
    logic [OFF_W-1:0]   iidx;
    always_comb begin
        irot = '0;
        iidx = '0;
        for (int j = 0; j < LANES; j++) begin
            iidx = ioff_q + OFF_W'(j);
            irot[8*j +: 8] = ilane[8*iidx +: 8];
        end
    end

    // Select and rotate only the DATA_BYTES lanes of the data access.
    logic [8*DATA_BYTES-1:0] drot;
    logic [OFF_W-1:0]        didx;
    always_comb begin
        drot = '0;
        didx = '0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            didx = doff_q + OFF_W'(j);
            drot[8*j +: 8] = dlane[8*didx +: 8];
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [8*LANES-1:0]      idata_q;
        logic [8*DATA_BYTES-1:0] drdata_q;
        logic                    ivalid_q, dvalid_q;

        // Extra output register after the rotate; loads only on valid so data holds otherwise.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                idata_q  <= '0;
                drdata_q <= '0;
                ivalid_q <= 1'b0;
                dvalid_q <= 1'b0;
            end else begin
                ivalid_q <= ivld_q;
                dvalid_q <= dvld_q;
                if (ivld_q) begin
                    idata_q <= irot;
                end
                if (dvld_q) begin
                    drdata_q <= drot;
                end
            end
        end

        assign idata  = idata_q;
        assign ivalid = ivalid_q;
        assign drdata = drdata_q;
        assign dvalid = dvalid_q;
    end else begin : g_lat1
        assign idata  = irot;
        assign ivalid = ivld_q;
        assign drdata = drot;
        assign dvalid = dvld_q;
    end

endmodule

// File: tb/tb_lane_ram.sv
// tb_lane_ram: checks lane_ram at RD_LAT=1 and RD_LAT=2 side by side on the same stimulus.
// Byte-array reference model with known-byte masks, a directed vector table, and random traffic.
// Both instances use LANES=4, DATA_BYTES=2, ADR_W=16.
module tb_lane_ram;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] iadr, dadr, dwdata;
    logic        ien, dre;
    logic [1:0]  dwe;
    logic [31:0] idata1, idata2;
    logic [15:0] drdata1, drdata2;
    logic        ivalid1, ivalid2, dvalid1, dvalid2;

    lane_ram #(.LANES(4), .DATA_BYTES(2), .ADR_W(16), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .iadr(iadr), .ien(ien), .idata(idata1), .ivalid(ivalid1),
        .dadr(dadr), .dre(dre), .dwe(dwe), .dwdata(dwdata), .drdata(drdata1), .dvalid(dvalid1)
    );
    lane_ram #(.LANES(4), .DATA_BYTES(2), .ADR_W(16), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .iadr(iadr), .ien(ien), .idata(idata2), .ivalid(ivalid2),
        .dadr(dadr), .dre(dre), .dwe(dwe), .dwdata(dwdata), .drdata(drdata2), .dvalid(dvalid2)
    );

    int total = 0;
    int bad   = 0;

    // Reference memory: plain byte array plus a flag for bytes that have been written.
    logic [7:0] ref_mem [65536];
    bit         ref_known [65536];

    // Expected visible outputs of each instance (value plus mask of known bytes).
    logic        m_iv1, m_iv2, m_dv1, m_dv2;
    logic [31:0] m_id1, m_im1, m_id2, m_im2;
    logic [15:0] m_dd1, m_dm1, m_dd2, m_dm2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_iv1 = 1'b0; m_iv2 = 1'b0; m_dv1 = 1'b0; m_dv2 = 1'b0;
        m_id1 = '0; m_id2 = '0; m_dd1 = '0; m_dd2 = '0;
        m_im1 = '1; m_im2 = '1; m_dm1 = '1; m_dm2 = '1;
    endtask

    task automatic peek(input logic [15:0] a, input int n, output logic [31:0] v, output logic [31:0] m);
        v = '0;
        m = '0;
        for (int j = 0; j < n; j++) begin
            logic [15:0] b;
            b = a + 16'(j);
            if (ref_known[b]) begin
                v[8*j +: 8] = ref_mem[b];
                m[8*j +: 8] = 8'hFF;
            end
        end
    endtask

    // Apply one clock edge of the current inputs to the model.
    task automatic model_edge();
        logic [31:0] fv, fm, rv, rm;
        fv = '0; fm = '0;
        if (reset) begin
            model_clear();
        end else begin
            m_iv2 = m_iv1;
            if (m_iv1) begin m_id2 = m_id1; m_im2 = m_im1; end
            m_dv2 = m_dv1;
            if (m_dv1) begin m_dd2 = m_dd1; m_dm2 = m_dm1; end
            peek(dadr, 2, rv, rm);
`ifndef LANE_RAM_BYPASS_EN
            peek(iadr, 4, fv, fm);
`endif
            for (int i = 0; i < 2; i++) begin
                if (dwe[i]) begin
                    ref_mem[dadr + 16'(i)]   = dwdata[8*i +: 8];
                    ref_known[dadr + 16'(i)] = 1'b1;
                end
            end
`ifdef LANE_RAM_BYPASS_EN
            peek(iadr, 4, fv, fm);
`endif
            m_iv1 = ien;
            if (ien) begin m_id1 = fv; m_im1 = fm; end
            m_dv1 = dre;
            if (dre) begin m_dd1 = rv[15:0]; m_dm1 = rm[15:0]; end
        end
    endtask

    task automatic check_all();
        chk("ivalid1", 32'(ivalid1), 32'(m_iv1));
        chk("idata1", idata1 & m_im1, m_id1 & m_im1);
        chk("dvalid1", 32'(dvalid1), 32'(m_dv1));
        chk("drdata1", 32'(drdata1 & m_dm1), 32'(m_dd1 & m_dm1));
        chk("ivalid2", 32'(ivalid2), 32'(m_iv2));
        chk("idata2", idata2 & m_im2, m_id2 & m_im2);
        chk("dvalid2", 32'(dvalid2), 32'(m_dv2));
        chk("drdata2", 32'(drdata2 & m_dm2), 32'(m_dd2 & m_dm2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        ien = 1'b0; dre = 1'b0; dwe = 2'b00; dwdata = '0;
    endtask

    typedef struct {
        logic        ien;
        logic [15:0] iadr;
        logic        dre;
        logic [15:0] dadr;
        logic [1:0]  dwe;
        logic [15:0] dwdata;
        logic [31:0] ei;
        logic [31:0] eim;
        logic [15:0] ed;
        logic [15:0] edm;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    initial begin
        logic [7:0]  coll;
        logic [1:0]  ipat [5];
        logic [31:0] ipat_d [5];
`ifdef LANE_RAM_BYPASS_EN
        coll = 8'h22;
`else
        coll = 8'h11;
`endif
        vec[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0003, 2'b11, 16'hBEEF, 32'h0, 32'h0, 16'h0, 16'h0};
        vec[1]  = '{1'b1, 16'h0002, 1'b1, 16'h0003, 2'b00, 16'h0000, 32'h00BEEF00, 32'h00FFFF00, 16'hBEEF, 16'hFFFF};
        vec[2]  = '{1'b0, 16'h0000, 1'b0, 16'hFFFF, 2'b11, 16'h1234, 32'h0, 32'h0, 16'h0, 16'h0};
        vec[3]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 2'b00, 16'h0000, 32'h0, 32'h0, 16'h1234, 16'hFFFF};
        vec[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0000, 2'b00, 16'h0000, 32'h0, 32'h0, 16'h0012, 16'h00FF};
        vec[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0010, 2'b11, 16'hAAAA, 32'h0, 32'h0, 16'h0, 16'h0};
        vec[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0010, 2'b01, 16'h5566, 32'h0, 32'h0, 16'h0, 16'h0};
        vec[7]  = '{1'b0, 16'h0000, 1'b1, 16'h0010, 2'b00, 16'h0000, 32'h0, 32'h0, 16'hAA66, 16'hFFFF};
        vec[8]  = '{1'b0, 16'h0000, 1'b1, 16'h0010, 2'b11, 16'h7788, 32'h0, 32'h0, 16'hAA66, 16'hFFFF};
        vec[9]  = '{1'b0, 16'h0000, 1'b1, 16'h0010, 2'b00, 16'h0000, 32'h0, 32'h0, 16'h7788, 16'hFFFF};
        vec[10] = '{1'b0, 16'h0000, 1'b0, 16'h0020, 2'b01, 16'h0011, 32'h0, 32'h0, 16'h0, 16'h0};
        vec[11] = '{1'b1, 16'h0020, 1'b0, 16'h0020, 2'b01, 16'h0022, {24'h0, coll}, 32'h000000FF, 16'h0, 16'h0};
        vec[12] = '{1'b1, 16'h0020, 1'b0, 16'h0000, 2'b00, 16'h0000, 32'h00000022, 32'h000000FF, 16'h0, 16'h0};
        vec[13] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 2'b00, 16'h0000, 32'h00001234, 32'h0000FFFF, 16'h0, 16'h0};

        // Reset state.
        reset = 1'b1;
        iadr = '0; dadr = '0;
        idle();
        model_clear();
        step();
        step();
        #2 reset = 1'b0;
        step();

        // Fill the wrapping region 0xFFE0..0x001F with byte = addr[7:0] ^ 0x5A.
        for (int r = 0; r < 64; r += 2) begin
            logic [15:0] a;
            a = 16'hFFE0 + 16'(r);
            dadr = a;
            dwe = 2'b11;
            dwdata = {a[7:0] ^ 8'h5B, a[7:0] ^ 8'h5A};
            step();
        end
        idle();
        step();

        // Directed vector table.
        for (int n = 0; n < NV; n++) begin
            ien = vec[n].ien; iadr = vec[n].iadr;
            dre = vec[n].dre; dadr = vec[n].dadr;
            dwe = vec[n].dwe; dwdata = vec[n].dwdata;
            step();
            chk($sformatf("vec%0d_ivalid", n), 32'(ivalid1), 32'(vec[n].ien));
            chk($sformatf("vec%0d_dvalid", n), 32'(dvalid1), 32'(vec[n].dre));
            if (vec[n].eim != 0) chk($sformatf("vec%0d_idata", n), idata1 & vec[n].eim, vec[n].ei);
            if (vec[n].edm != 0) chk($sformatf("vec%0d_drdata", n), 32'(drdata1 & vec[n].edm), 32'(vec[n].ed));
        end
        idle();
        step();

        // Back-to-back fetches through the two-cycle instance.
        // Bytes 0..5 now hold 12 5B 58 EF BE 5F.
        ipat   = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        ipat_d = '{32'h0, 32'hEF585B12, 32'hBEEF585B, 32'h5FBEEF58, 32'h5FBEEF58};
        for (int t = 0; t < 5; t++) begin
            ien  = (t < 3);
            iadr = 16'(t);
            step();
            chk($sformatf("lat2_ivalid_%0d", t), 32'(ivalid2), (t >= 1 && t <= 3) ? 32'd1 : 32'd0);
            if (t >= 1) chk($sformatf("lat2_idata_%0d", t), idata2, ipat_d[t]);
        end
        idle();
        step();

        // Asynchronous reset with requests in flight, then a write during reset.
        ien = 1'b1; iadr = 16'h0001; dre = 1'b1; dadr = 16'h0002;
        step();
        #3 reset = 1'b1;
        model_clear();
        #1;
        chk("rst_ivalid1", 32'(ivalid1), 32'd0);
        chk("rst_dvalid1", 32'(dvalid1), 32'd0);
        chk("rst_idata1", idata1, 32'd0);
        chk("rst_drdata1", 32'(drdata1), 32'd0);
        chk("rst_ivalid2", 32'(ivalid2), 32'd0);
        chk("rst_idata2", idata2, 32'd0);
        dadr = 16'h0005; dwe = 2'b11; dwdata = 16'hA5A5; iadr = 16'h0004;
        step();
        #2 reset = 1'b0;
        idle();
        step();
        chk("flush_ivalid2", 32'(ivalid2), 32'd0);
        chk("flush_dvalid2", 32'(dvalid2), 32'd0);
        dre = 1'b1; dadr = 16'h0005;
        step();
        chk("rst_write_dropped", 32'(drdata1), 32'h5C5F);
        idle();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            ien = 1'($urandom_range(0, 1));
            dre = 1'($urandom_range(0, 1));
            dwe = 2'($urandom_range(0, 3));
            dwdata = 16'($urandom);
            iadr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFE0 + 16'($urandom_range(0, 59));
            dadr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFE0 + 16'($urandom_range(0, 59));
            step();
        end
        idle();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_ram.md
Name: lane_ram

Overview:
- Parametrised byte-interleaved RAM with two ports: an unaligned instruction-fetch read port and an unaligned data read/write port.
- Successor to the fixed 4-lane, 16-bit-data CPU memory. Lane count, data width, depth and read latency are parameters.
- The rotate/lane-select logic and the registered select are internal to the block.
- Sits between the fz80wide-class CPU (pc_out/insn_in, adr_out/data_in/data_out) and the system bus; RAM arrays are inferred per lane.

Parameters:
LANES, 4, number of byte lanes; power of two, 2..8; fetch width = 8*LANES bits
DATA_BYTES, 2, data-port width in bytes; 1..LANES
ADR_W, 16, byte-address width; depth per lane = 2**ADR_W / LANES rows
RD_LAT, 1, read latency in cycles for both ports; 1 or 2

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-high
iadr  input  ADR_W  fetch byte address, any alignment
ien  input  1  fetch request
idata  output  8*LANES  bytes iadr..iadr+LANES-1, little-endian (byte iadr in [7:0])
ivalid  output  1  idata valid
dadr  input  ADR_W  data byte address, any alignment
dre  input  1  data read request
dwe  input  DATA_BYTES  per-byte write enable; byte i targets dadr+i
dwdata  input  8*DATA_BYTES  write data, byte i in [8i+7:8i]
drdata  output  8*DATA_BYTES  bytes dadr..dadr+DATA_BYTES-1, little-endian
dvalid  output  1  drdata valid

Behaviour:
- Mapping: byte address b is held in lane b mod LANES, row b / LANES.
- Per-request row for lane k: base = adr/LANES, off = adr mod LANES; row = base+1 if k < off, else base.
- The row add is modulo depth, so accesses wrap from the top of the address space to address 0.
- Fetch: the request is sampled on clk when ien=1. idata/ivalid update RD_LAT cycles later.
- Fetch rotation: the off value is registered with the request and used to rotate the lane outputs into byte order.
- ivalid = ien delayed RD_LAT cycles. idata holds its last value while ivalid=0.
- Data read: same rules as fetch, using dre, dadr, drdata, dvalid. Only DATA_BYTES lanes are selected.
- Data write: when dwe[i]=1, byte dwdata[8i+7:8i] is written to dadr+i at the sampling edge. Byte enables are independent; any pattern is legal, including 0.
- dre and dwe together at the same address: drdata returns the pre-write (old) contents (read-first).
- Fetch and data write hitting the same byte in the same cycle: idata returns the old byte, unless LANE_RAM_BYPASS_EN is defined.
- Both ports may access any addresses simultaneously; no stall and no arbitration. Throughput is 1 request per port per cycle.
- RD_LAT=2: adds one output register stage after the rotate. Requests stay fully pipelined; back-to-back requests return back-to-back.
- Reset:
  - idata, drdata, ivalid and dvalid go to 0 immediately. Pipeline valid bits and registered offsets are cleared.
  - RAM contents are not cleared.
  - Requests sampled on any edge while reset=1 are discarded: no write, no valid.
  - Requests in flight when reset asserts never produce a valid.
- RAM contents at power-up are undefined; the bench initialises RAM by writes.

Optional Feature:
LANE_RAM_BYPASS_EN
- Defined: a fetch that reads a byte being written through the data port in the same cycle returns the new byte (write-to-fetch forwarding, per byte, per lane). Also applies across the RD_LAT=2 stage.
- Not defined: read-first; the fetch returns the old byte.
- Data-port read/write collision is read-first in both builds.

Test Plan:
1. LANES=4, DATA_BYTES=2. Write dadr=0x0003, dwe=2'b11, dwdata=0xBEEF. Then fetch iadr=0x0002 → next cycle ivalid=1, idata[15:8]=0xEF, idata[23:16]=0xBE. Data read dadr=0x0003 → drdata=0xBEEF.
2. Wrap-around: write dadr=0xFFFF, dwdata=0x1234. Then read dadr=0xFFFF → drdata=0x1234. Read dadr=0x0000 with dwe=0 → drdata[7:0]=0x12.
3. Byte enables: preload 0x0010..0x0011 with 0xAAAA, then write dwdata=0x5566 with dwe=2'b01 → read 0x0010 returns 0xAA66.
4. Collision: memory at 0x0020 = 0x11. Same cycle: write dadr=0x0020 data 0x22, fetch iadr=0x0020.
   - Without LANE_RAM_BYPASS_EN: idata[7:0]=0x11.
   - With LANE_RAM_BYPASS_EN: idata[7:0]=0x22.
   - Both builds: a later fetch returns 0x22.
5. RD_LAT=2: fetches at 0x0000, 0x0001, 0x0002 on consecutive cycles → ivalid high for exactly 3 consecutive cycles starting 2 cycles after the first request, with correctly rotated data.
6. Assert reset asynchronously mid-cycle with fetch and read in flight → ivalid, dvalid, idata and drdata go to 0 without waiting for a clock edge. No valid is produced for the flushed requests. A write issued during reset leaves memory unchanged.
